packet_data_buffer: RTL and testbench

- Parametrised successor to the 64-byte USB/AHB endpoint data buffer: a byte-organised ring FIFO between the USB RX/TX byte paths and the AHB-Lite slave word path.
- Adds configurable depth and word width.
- Adds RX-packet checkpointing: the protocol FSM commits a good packet or rolls it back on CRC/PID error.
- Adds sticky overflow/underflow flags and full/empty status.

---
 rtl/packet_data_buffer_if.sv | 44 ++++
 rtl/packet_data_buffer.sv | 166 ++++++++++++++++
 tb/tb_packet_data_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/packet_data_buffer_if.sv
// Handshake/bus bundle between the USB protocol engine, the AHB-Lite slave
// and the packet data buffer.
interface packet_data_buffer_if #(
  parameter int DEPTH      = 64,
  parameter int WORD_BYTES = 4
);
  localparam int SIZE_W = $clog2(WORD_BYTES);
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic                    clear;
  logic                    buffer_reserved;
  logic                    store_rx_packet_data;
  logic [7:0]              rx_packet_data;
  logic                    rx_packet_commit;
  logic                    rx_packet_discard;
  logic                    get_rx_data;
  logic                    store_tx_data;
  logic [SIZE_W-1:0]       data_size;
  logic [8*WORD_BYTES-1:0] tx_data;
  logic                    get_tx_packet_data;
  logic [OCC_W-1:0]        buffer_occupancy;
  logic [8*WORD_BYTES-1:0] rx_data;
  logic [7:0]              tx_packet_data;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output clear, buffer_reserved, store_rx_packet_data, rx_packet_data,
           rx_packet_commit, rx_packet_discard, get_rx_data, store_tx_data,
           data_size, tx_data, get_tx_packet_data,
    input  buffer_occupancy, rx_data, tx_packet_data, full, empty,
           overflow, underflow
  );

  modport slave (
    input  clear, buffer_reserved, store_rx_packet_data, rx_packet_data,
           rx_packet_commit, rx_packet_discard, get_rx_data, store_tx_data,
           data_size, tx_data, get_tx_packet_data,
    output buffer_occupancy, rx_data, tx_packet_data, full, empty,
           overflow, underflow
  );
endinterface

// File: rtl/packet_data_buffer.sv
// Byte-organised ring FIFO between the USB RX/TX byte paths and the AHB-Lite
// word path, with RX packet commit/rollback and sticky error flags.
module packet_data_buffer #(
  parameter int DEPTH      = 64,
  parameter int WORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  packet_data_buffer_if.slave   bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);

  logic [7:0]        mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, mark_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              full_r, empty_r, overflow_r, underflow_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [7:0]        tx_byte_r;

  logic [PTR_W-1:0]  occ_s, push_len_s, pop_len_s, rd_nxt_s, wr_nxt_s;
  logic [PTR_W-1:0]  mark_eff_s, mark_nxt_s, occ_nxt_s;
  logic [PTR_W:0]    occ_ext_s, n_s;
  logic              rx_push_act_s, tx_push_ok_s, rx_push_ok_s, push_ovf_s;
  logic              rx_pop_ok_s, tx_pop_ok_s, pop_unf_s, mark_passed_s;
  logic [DATA_W-1:0] rd_data_s;

  function automatic logic [AW-1:0] byte_addr(input logic [PTR_W-1:0] base,
                                              input int unsigned      off);
    return base[AW-1:0] + off[AW-1:0];
  endfunction

  // Next-state pointer arithmetic, arbitration and error detection
  always_comb begin
    occ_s         = wr_ptr_r - rd_ptr_r;
    occ_ext_s     = {1'b0, occ_s};
    n_s           = (PTR_W + 1)'(bus.data_size) + (PTR_W + 1)'(1);
    rx_push_act_s = bus.store_rx_packet_data & ~bus.buffer_reserved & ~bus.rx_packet_discard;
    tx_push_ok_s  = bus.store_tx_data & ~bus.rx_packet_discard & ((occ_ext_s + n_s) <= DEPTH_EXT);
    rx_push_ok_s  = ~bus.store_tx_data & rx_push_act_s & (occ_ext_s < DEPTH_EXT);
    // A same-cycle TX store also counts as a rejected RX push
    push_ovf_s    = (bus.store_tx_data & ~bus.rx_packet_discard & ~tx_push_ok_s)
                  | (rx_push_act_s & ~rx_push_ok_s);
    rx_pop_ok_s   = bus.get_rx_data & (occ_ext_s >= n_s);
    tx_pop_ok_s   = ~bus.get_rx_data & bus.get_tx_packet_data & (occ_s != PTR_W'(0));
    pop_unf_s     = (bus.get_rx_data & ~rx_pop_ok_s) | (bus.get_tx_packet_data & ~tx_pop_ok_s);

    if (tx_push_ok_s) begin
      push_len_s = n_s[PTR_W-1:0];
    end else if (rx_push_ok_s) begin
      push_len_s = PTR_W'(1);
    end else begin
      push_len_s = PTR_W'(0);
    end

    if (rx_pop_ok_s) begin
      pop_len_s = n_s[PTR_W-1:0];
    end else if (tx_pop_ok_s) begin
      pop_len_s = PTR_W'(1);
    end else begin
      pop_len_s = PTR_W'(0);
    end

    rd_nxt_s = rd_ptr_r + pop_len_s;
    // Keep the checkpoint inside [rd, wr] so a rollback never rewinds behind the reader
    mark_passed_s = (mark_ptr_r - rd_nxt_s) > (wr_ptr_r - rd_nxt_s);
    if (mark_passed_s) begin
      mark_eff_s = rd_nxt_s;
    end else begin
      mark_eff_s = mark_ptr_r;
    end

    if (bus.rx_packet_discard) begin
      wr_nxt_s   = mark_eff_s;
      mark_nxt_s = mark_eff_s;
    end else begin
      wr_nxt_s = wr_ptr_r + push_len_s;
      if (bus.rx_packet_commit | tx_push_ok_s) begin
        mark_nxt_s = wr_nxt_s;
      end else begin
        mark_nxt_s = mark_eff_s;
      end
    end
    occ_nxt_s = wr_nxt_s - rd_nxt_s;
  end

  // Gather up to WORD_BYTES bytes from the read pointer, zero above the request
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < WORD_BYTES; i++) begin
      if ((PTR_W + 1)'(i) < n_s) begin
        rd_data_s[8*i +: 8] = mem_r[byte_addr(rd_ptr_r, i)];
      end else begin
        rd_data_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Byte storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (!bus.clear) begin
      if (tx_push_ok_s) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if ((PTR_W + 1)'(i) < n_s) begin
            mem_r[byte_addr(wr_ptr_r, i)] <= bus.tx_data[8*i +: 8];
          end
        end
      end else if (rx_push_ok_s) begin
        mem_r[byte_addr(wr_ptr_r, 0)] <= bus.rx_packet_data;
      end
    end
  end

  // Pointers, status, sticky flags and registered read data
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_r    <= PTR_W'(0);
      wr_ptr_r    <= PTR_W'(0);
      mark_ptr_r  <= PTR_W'(0);
      occ_r       <= OCC_W'(0);
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      rx_data_r   <= {DATA_W{1'b0}};
      tx_byte_r   <= 8'h00;
    end else if (bus.clear) begin
      rd_ptr_r    <= PTR_W'(0);
      wr_ptr_r    <= PTR_W'(0);
      mark_ptr_r  <= PTR_W'(0);
      occ_r       <= OCC_W'(0);
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      rx_data_r   <= {DATA_W{1'b0}};
      tx_byte_r   <= 8'h00;
    end else begin
      rd_ptr_r    <= rd_nxt_s;
      wr_ptr_r    <= wr_nxt_s;
      mark_ptr_r  <= mark_nxt_s;
      occ_r       <= OCC_W'(occ_nxt_s);
      full_r      <= (occ_nxt_s == PTR_W'(DEPTH));
      empty_r     <= (occ_nxt_s == PTR_W'(0));
      overflow_r  <= overflow_r | push_ovf_s;
      underflow_r <= underflow_r | pop_unf_s;
      if (rx_pop_ok_s) begin
        rx_data_r <= rd_data_s;
      end
      if (tx_pop_ok_s) begin
        tx_byte_r <= mem_r[byte_addr(rd_ptr_r, 0)];
      end
    end
  end

  assign bus.buffer_occupancy = occ_r;
  assign bus.full             = full_r;
  assign bus.empty            = empty_r;
  assign bus.overflow         = overflow_r;
  assign bus.underflow        = underflow_r;
  assign bus.rx_data          = rx_data_r;
  assign bus.tx_packet_data   = tx_byte_r;
endmodule

// File: tb/tb_packet_data_buffer.sv
// Directed self-checking bench for packet_data_buffer (DEPTH=64, WORD_BYTES=4).
module tb_packet_data_buffer;
  localparam int DEPTH = 64;
  localparam int WB    = 4;

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  packet_data_buffer_if #(.DEPTH(DEPTH), .WORD_BYTES(WB)) bus ();
  packet_data_buffer #(.DEPTH(DEPTH), .WORD_BYTES(WB)) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 tb_clk = ~tb_clk;

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7) + 3);
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle();
    bus.clear = 1'b0; bus.buffer_reserved = 1'b0; bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data = 8'h00; bus.rx_packet_commit = 1'b0; bus.rx_packet_discard = 1'b0;
    bus.get_rx_data = 1'b0; bus.store_tx_data = 1'b0; bus.data_size = 2'd0;
    bus.tx_data = 32'h0; bus.get_tx_packet_data = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = b; tick(); idle();
  endtask

  task automatic tx_push(input logic [1:0] sz, input logic [31:0] d);
    bus.store_tx_data = 1'b1; bus.data_size = sz; bus.tx_data = d; tick(); idle();
  endtask

  task automatic rx_pop(input logic [1:0] sz);
    bus.get_rx_data = 1'b1; bus.data_size = sz; tick(); idle();
  endtask

  task automatic tx_pop();
    bus.get_tx_packet_data = 1'b1; tick(); idle();
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); n_rst = 1'b0; repeat (2) tick();
    tests_run++; if (bus.buffer_occupancy !== 7'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d want 0", bus.buffer_occupancy); end
    tests_run++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_status: empty=%b full=%b want 1/0", bus.empty, bus.full); end
    tests_run++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: ovf=%b unf=%b want 0/0", bus.overflow, bus.underflow); end
    tests_run++; if (bus.rx_data !== 32'h0 || bus.tx_packet_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: rx=%h tx=%h want 0/0", bus.rx_data, bus.tx_packet_data); end
    n_rst = 1'b1; tick();
  endtask

  task automatic test_rx_commit_pop();
    rx_push(8'hFF); rx_push(8'hC9); rx_push(8'h9A); rx_push(8'h3B);
    bus.rx_packet_commit = 1'b1; tick(); idle();
    tests_run++; if (bus.buffer_occupancy !== 7'd4) begin tests_failed++; $display("FAIL rx_occ: got %0d want 4", bus.buffer_occupancy); end
    rx_pop(2'd3);
    tests_run++; if (bus.rx_data !== 32'h3B9AC9FF) begin tests_failed++; $display("FAIL rx_word: got %h want 3b9ac9ff", bus.rx_data); end
    tests_run++; if (bus.buffer_occupancy !== 7'd0 || bus.empty !== 1'b1) begin tests_failed++; $display("FAIL rx_drained: occ=%0d empty=%b want 0/1", bus.buffer_occupancy, bus.empty); end
  endtask

  task automatic test_tx_bytes();
    tx_push(2'd1, 32'h00002B67);
    tests_run++; if (bus.buffer_occupancy !== 7'd2) begin tests_failed++; $display("FAIL tx_occ: got %0d want 2", bus.buffer_occupancy); end
    tx_pop();
    tests_run++; if (bus.tx_packet_data !== 8'h67) begin tests_failed++; $display("FAIL tx_byte0: got %h want 67", bus.tx_packet_data); end
    tx_pop();
    tests_run++; if (bus.tx_packet_data !== 8'h2B) begin tests_failed++; $display("FAIL tx_byte1: got %h want 2b", bus.tx_packet_data); end
    tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL tx_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_fill_wrap();
    for (int w = 0; w < 16; w++)
      tx_push(2'd3, {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)});
    tests_run++; if (bus.full !== 1'b1 || bus.buffer_occupancy !== 7'd64) begin tests_failed++; $display("FAIL fill_full: full=%b occ=%0d want 1/64", bus.full, bus.buffer_occupancy); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_no_ovf: got %b want 0", bus.overflow); end
    tx_push(2'd0, 32'h000000EE);
    tests_run++; if (bus.overflow !== 1'b1 || bus.buffer_occupancy !== 7'd64) begin tests_failed++; $display("FAIL fill_ovf: ovf=%b occ=%0d want 1/64", bus.overflow, bus.buffer_occupancy); end
    for (int k = 0; k < 64; k++) begin
      tx_pop();
      tests_run++; if (bus.tx_packet_data !== pat(k)) begin tests_failed++; $display("FAIL drain_byte%0d: got %h want %h", k, bus.tx_packet_data, pat(k)); end
    end
    tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    // Pointers sit at byte 70 (address 6); 54 single-byte round trips reach address 60
    for (int k = 0; k < 54; k++) begin
      tx_push(2'd0, 32'h0); tx_pop();
    end
    tx_push(2'd3, 32'h44332211); tx_push(2'd3, 32'h88776655);
    tests_run++; if (bus.buffer_occupancy !== 7'd8) begin tests_failed++; $display("FAIL wrap_occ: got %0d want 8", bus.buffer_occupancy); end
    rx_pop(2'd3);
    tests_run++; if (bus.rx_data !== 32'h44332211) begin tests_failed++; $display("FAIL wrap_word0: got %h want 44332211", bus.rx_data); end
    rx_pop(2'd3);
    tests_run++; if (bus.rx_data !== 32'h88776655) begin tests_failed++; $display("FAIL wrap_word1: got %h want 88776655", bus.rx_data); end
  endtask

  task automatic test_checkpoint();
    pulse_clear();
    tests_run++; if (bus.overflow !== 1'b0 || bus.buffer_occupancy !== 7'd0) begin tests_failed++; $display("FAIL clear: ovf=%b occ=%0d want 0/0", bus.overflow, bus.buffer_occupancy); end
    for (int k = 0; k < 5; k++) rx_push(8'h10 + 8'(k));
    bus.rx_packet_commit = 1'b1; tick(); idle();
    rx_push(8'h20); rx_push(8'h21); rx_push(8'h22);
    tests_run++; if (bus.buffer_occupancy !== 7'd8) begin tests_failed++; $display("FAIL ckpt_pre: got %0d want 8", bus.buffer_occupancy); end
    bus.rx_packet_discard = 1'b1; tick(); idle();
    tests_run++; if (bus.buffer_occupancy !== 7'd5) begin tests_failed++; $display("FAIL ckpt_discard: got %0d want 5", bus.buffer_occupancy); end
    rx_pop(2'd3);
    tests_run++; if (bus.rx_data !== 32'h13121110) begin tests_failed++; $display("FAIL ckpt_word: got %h want 13121110", bus.rx_data); end
    tx_pop();
    tests_run++; if (bus.tx_packet_data !== 8'h14) begin tests_failed++; $display("FAIL ckpt_last: got %h want 14", bus.tx_packet_data); end
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL ckpt_no_unf: got %b want 0", bus.underflow); end
    tx_pop();
    tests_run++; if (bus.underflow !== 1'b1 || bus.tx_packet_data !== 8'h14) begin tests_failed++; $display("FAIL ckpt_unf: unf=%b tx=%h want 1/14", bus.underflow, bus.tx_packet_data); end
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    rx_push(8'h5C);
    bus.rx_packet_commit = 1'b1; tick(); idle();
    bus.get_rx_data = 1'b1; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'hA5; tick(); idle();
    tests_run++; if (bus.rx_data !== 32'h0000005C || bus.buffer_occupancy !== 7'd1) begin tests_failed++; $display("FAIL simul_occ1: rx=%h occ=%0d want 5c/1", bus.rx_data, bus.buffer_occupancy); end
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL simul_no_unf: got %b want 0", bus.underflow); end
    rx_pop(2'd0);
    tests_run++; if (bus.rx_data !== 32'h000000A5 || bus.empty !== 1'b1) begin tests_failed++; $display("FAIL simul_pop: rx=%h empty=%b want a5/1", bus.rx_data, bus.empty); end
    bus.get_rx_data = 1'b1; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'hA5; tick(); idle();
    tests_run++; if (bus.underflow !== 1'b1 || bus.buffer_occupancy !== 7'd1 || bus.rx_data !== 32'h000000A5) begin tests_failed++; $display("FAIL simul_occ0: unf=%b occ=%0d rx=%h want 1/1/a5", bus.underflow, bus.buffer_occupancy, bus.rx_data); end
  endtask

  task automatic test_arbitration_reset();
    pulse_clear();
    bus.buffer_reserved = 1'b1; bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h99; tick(); idle();
    tests_run++; if (bus.buffer_occupancy !== 7'd0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL reserved: occ=%0d ovf=%b unf=%b want 0/0/0", bus.buffer_occupancy, bus.overflow, bus.underflow); end
    bus.store_tx_data = 1'b1; bus.data_size = 2'd1; bus.tx_data = 32'h0000BEEF;
    bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h77; tick(); idle();
    tests_run++; if (bus.buffer_occupancy !== 7'd2 || bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL push_arb: occ=%0d ovf=%b want 2/1", bus.buffer_occupancy, bus.overflow); end
    rx_pop(2'd1);
    tests_run++; if (bus.rx_data !== 32'h0000BEEF) begin tests_failed++; $display("FAIL push_arb_data: got %h want 0000beef", bus.rx_data); end
    tx_push(2'd1, 32'h00001122);
    bus.get_rx_data = 1'b1; bus.data_size = 2'd0; bus.get_tx_packet_data = 1'b1; tick(); idle();
    tests_run++; if (bus.rx_data !== 32'h00000022 || bus.underflow !== 1'b1 || bus.buffer_occupancy !== 7'd1 || bus.tx_packet_data !== 8'h00) begin tests_failed++; $display("FAIL pop_arb: rx=%h unf=%b occ=%0d tx=%h want 22/1/1/00", bus.rx_data, bus.underflow, bus.buffer_occupancy, bus.tx_packet_data); end
    bus.store_tx_data = 1'b1; bus.data_size = 2'd3; bus.tx_data = 32'hCAFEF00D;
    @(posedge tb_clk); #2; n_rst = 1'b0; #1;
    tests_run++; if (bus.buffer_occupancy !== 7'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin tests_failed++; $display("FAIL async_rst_status: occ=%0d empty=%b full=%b want 0/1/0", bus.buffer_occupancy, bus.empty, bus.full); end
    tests_run++; if (bus.rx_data !== 32'h0 || bus.tx_packet_data !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL async_rst_data: rx=%h tx=%h ovf=%b unf=%b want all 0", bus.rx_data, bus.tx_packet_data, bus.overflow, bus.underflow); end
    idle(); tick(); n_rst = 1'b1; tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_rx_commit_pop();
    test_tx_bytes();
    test_fill_wrap();
    test_checkpoint();
    test_simultaneous();
    test_arbitration_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
